// File: rtl/four_bit_serial_adder_pkg.sv
// rtl/four_bit_serial_adder_pkg.sv - shared state encoding and width constants for the serial adder
package four_bit_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned OP_WIDTH = 4;
  localparam logic [1:0]  LAST_BIT = 2'd3;

endpackage

// File: rtl/four_bit_serial_adder_one_bit_adder.sv
// rtl/four_bit_serial_adder_one_bit_adder.sv - combinational full-adder cell
module one_bit_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/four_bit_serial_adder.sv
// rtl/four_bit_serial_adder.sv - bit-serial 4-bit adder, LSB first through one full-adder cell
module four_bit_serial_adder
  import four_bit_serial_adder_pkg::*;
#(
  parameter bit AUTO_CLEAR = 1'b1
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Start,
  input  logic Enable,
  input  logic A3,
  input  logic A2,
  input  logic A1,
  input  logic A0,
  input  logic B3,
  input  logic B2,
  input  logic B1,
  input  logic B0,
  input  logic Cin,
  output logic Sum3,
  output logic Sum2,
  output logic Sum1,
  output logic Sum0,
  output logic Cout,
  output logic Busy,
  output logic Done
);

  state_e                state_q, state_d;
  logic [OP_WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [OP_WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [OP_WIDTH-1:0]   sum_sh_q, sum_sh_d;
  logic                  carry_q, carry_d;
  logic [1:0]            count_q, count_d;
  logic                  cout_q, cout_d;
  logic                  done_q, done_d;
  logic                  fa_s, fa_c;
  logic                  accept;

  one_bit_adder u_fa (
    .A    (a_sh_q[0]),
    .B    (b_sh_q[0]),
    .Cin  (carry_q),
    .Sum  (fa_s),
    .Cout (fa_c)
  );

  assign accept = Start & Enable;

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    count_d  = count_q;
    cout_d   = cout_q;
    done_d   = done_q;

    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE && AUTO_CLEAR) begin
          done_d = 1'b0;
        end
        if (accept) begin
          a_sh_d   = {A3, A2, A1, A0};
          b_sh_d   = {B3, B2, B1, B0};
          carry_d  = Cin;
          count_d  = 2'd0;
          sum_sh_d = '0;
          done_d   = 1'b0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (!Enable) begin
          // Abort: discard the partial result so nothing stale is presented.
          state_d  = IDLE;
          sum_sh_d = '0;
          carry_d  = 1'b0;
          cout_d   = 1'b0;
          done_d   = 1'b0;
        end else begin
          sum_sh_d = {fa_s, sum_sh_q[OP_WIDTH-1:1]};
          a_sh_d   = {1'b0, a_sh_q[OP_WIDTH-1:1]};
          b_sh_d   = {1'b0, b_sh_q[OP_WIDTH-1:1]};
          carry_d  = fa_c;
          count_d  = count_q + 2'd1;
          if (count_q == LAST_BIT) begin
            cout_d  = fa_c;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      count_q  <= 2'd0;
      cout_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      count_q  <= count_d;
      cout_q   <= cout_d;
      done_q   <= done_d;
    end
  end

  assign {Sum3, Sum2, Sum1, Sum0} = Enable ? sum_sh_q : '0;
  assign Cout = Enable & cout_q;
  assign Busy = (state_q == SHIFT);
  assign Done = done_q;

endmodule
